// File: rtl/unidade_controle_jogo_pkg.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo_pkg
// Shared definitions for the memory-game controller and the datapath debug
// hex decoder: state register width, state codes and a terminal-state helper.
// -----------------------------------------------------------------------------
package unidade_controle_jogo_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] ST_INICIAL     = 4'b0000;
  localparam logic [STATE_W-1:0] ST_PREPARACAO  = 4'b0001;
  localparam logic [STATE_W-1:0] ST_ESPERA      = 4'b0010;
  localparam logic [STATE_W-1:0] ST_REGISTRA    = 4'b0100;
  localparam logic [STATE_W-1:0] ST_COMPARACAO  = 4'b0101;
  localparam logic [STATE_W-1:0] ST_PROXIMO     = 4'b0110;
  localparam logic [STATE_W-1:0] ST_FIM_ACERTOU = 4'b1010;
  localparam logic [STATE_W-1:0] ST_FIM_ERROU   = 4'b1110;
  localparam logic [STATE_W-1:0] ST_FIM_TIMEOUT = 4'b1101;

  // True for the three states that end a game.
  function automatic logic is_terminal(input logic [STATE_W-1:0] st);
    return (st == ST_FIM_ACERTOU) || (st == ST_FIM_ERROU) ||
           (st == ST_FIM_TIMEOUT);
  endfunction

endpackage

// File: rtl/unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo
// Moore controller sequencing the memory-game datapath through 16 moves.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-low; forces inicial
//   iniciar      in   level; starts/restarts a game from inicial or a terminal
//   fimC         in   address counter at its last position
//   igual        in   ROM data equals the registered move
//   jogada_feita in   one-cycle pulse on a new move
//   fimT         in   move-timeout counter expired
//   zeraC        out  clear address counter, timeout counter, edge detector
//   contaC       out  advance address counter
//   zeraR        out  clear move register
//   registraR    out  load move register
//   conta        out  enable timeout counter
//   pronto       out  game over (any terminal state)
//   acertou      out  all moves correct
//   errou        out  wrong move
//   timeout      out  no move before timeout
//   db_estado    out  current state code
// -----------------------------------------------------------------------------
module unidade_controle_jogo
  import unidade_controle_jogo_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               fimC,
  input  logic               igual,
  input  logic               jogada_feita,
  input  logic               fimT,
  output logic               zeraC,
  output logic               contaC,
  output logic               zeraR,
  output logic               registraR,
  output logic               conta,
  output logic               pronto,
  output logic               acertou,
  output logic               errou,
  output logic               timeout,
  output logic [STATE_W-1:0] db_estado
);

  logic [STATE_W-1:0] r_estado;
  logic [STATE_W-1:0] w_proximo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= ST_INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  always_comb begin
    w_proximo = ST_INICIAL;
    case (r_estado)
      ST_INICIAL:     w_proximo = iniciar ? ST_PREPARACAO : ST_INICIAL;
      ST_PREPARACAO:  w_proximo = ST_ESPERA;
      // A move arriving in the same cycle as the timeout still counts.
      ST_ESPERA: begin
        if (jogada_feita)  w_proximo = ST_REGISTRA;
        else if (fimT)     w_proximo = ST_FIM_TIMEOUT;
        else               w_proximo = ST_ESPERA;
      end
      ST_REGISTRA:    w_proximo = ST_COMPARACAO;
      // A miss takes priority over reaching the last address.
      ST_COMPARACAO: begin
        if (!igual)        w_proximo = ST_FIM_ERROU;
        else if (fimC)     w_proximo = ST_FIM_ACERTOU;
        else               w_proximo = ST_PROXIMO;
      end
      ST_PROXIMO:     w_proximo = ST_ESPERA;
      ST_FIM_ACERTOU: w_proximo = iniciar ? ST_PREPARACAO : ST_FIM_ACERTOU;
      ST_FIM_ERROU:   w_proximo = iniciar ? ST_PREPARACAO : ST_FIM_ERROU;
      ST_FIM_TIMEOUT: w_proximo = iniciar ? ST_PREPARACAO : ST_FIM_TIMEOUT;
      // Unused codes recover to inicial.
      default:        w_proximo = ST_INICIAL;
    endcase
  end

  always_comb begin
    zeraC     = 1'b0;
    contaC    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    conta     = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    case (r_estado)
      ST_PREPARACAO: begin
        zeraC = 1'b1;
        zeraR = 1'b1;
      end
      ST_ESPERA:      conta     = 1'b1;
      ST_REGISTRA:    registraR = 1'b1;
      ST_PROXIMO:     contaC    = 1'b1;
      ST_FIM_ACERTOU: acertou   = 1'b1;
      ST_FIM_ERROU:   errou     = 1'b1;
      ST_FIM_TIMEOUT: timeout   = 1'b1;
      default: ;
    endcase
  end

  assign pronto    = is_terminal(r_estado);
  assign db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
module tb_unidade_controle_jogo;
  import unidade_controle_jogo_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0, fimC = 1'b0, igual = 1'b0, jogada_feita = 1'b0, fimT = 1'b0;
  logic zeraC, contaC, zeraR, registraR, conta, pronto, acertou, errou, timeout;
  logic [STATE_W-1:0] db_estado;

  unidade_controle_jogo dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fimC(fimC),
    .igual(igual), .jogada_feita(jogada_feita), .fimT(fimT),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
    .conta(conta), .pronto(pronto), .acertou(acertou), .errou(errou),
    .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Game phases of the reference model, independent of the DUT encoding.
  typedef enum {M_INI, M_PREP, M_ESP, M_REG, M_CMP, M_PROX, M_OK, M_ERR, M_TO, M_BAD} mstate_t;

  mstate_t m;
  int n_vec = 0;
  int n_err = 0;
  int n_conta = 0;

  logic [12:0] w_obs;
  assign w_obs = {db_estado, zeraC, contaC, zeraR, registraR, conta,
                  pronto, acertou, errou, timeout};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {code, zeraC, contaC, zeraR, registraR, conta, pronto, acertou, errou, timeout}.
  function automatic logic [12:0] expect_of(input mstate_t s);
    case (s)
      M_INI:   return {4'b0000, 9'b000000000};
      M_PREP:  return {4'b0001, 9'b101000000};
      M_ESP:   return {4'b0010, 9'b000010000};
      M_REG:   return {4'b0100, 9'b000100000};
      M_CMP:   return {4'b0101, 9'b000000000};
      M_PROX:  return {4'b0110, 9'b010000000};
      M_OK:    return {4'b1010, 9'b000001100};
      M_ERR:   return {4'b1110, 9'b000001010};
      M_TO:    return {4'b1101, 9'b000001001};
      default: return {4'b1111, 9'b000000000};
    endcase
  endfunction

  function automatic mstate_t nxt(input mstate_t s, input logic ini, input logic fc,
                                  input logic ig, input logic jf, input logic ft);
    case (s)
      M_INI:  return ini ? M_PREP : M_INI;
      M_PREP: return M_ESP;
      M_ESP:  return jf ? M_REG : (ft ? M_TO : M_ESP);
      M_REG:  return M_CMP;
      M_CMP:  return !ig ? M_ERR : (fc ? M_OK : M_PROX);
      M_PROX: return M_ESP;
      M_OK, M_ERR, M_TO: return ini ? M_PREP : s;
      default: return M_INI;
    endcase
  endfunction

  // One clock: drive inputs (called at a falling edge), advance model, check.
  task automatic step(input string tag, input logic ini, input logic fc,
                      input logic ig, input logic jf, input logic ft);
    iniciar = ini; fimC = fc; igual = ig; jogada_feita = jf; fimT = ft;
    @(posedge clock);
    if (reset) m = nxt(m, ini, fc, ig, jf, ft);
    @(negedge clock);
    chk(tag, {19'd0, w_obs}, {19'd0, expect_of(m)});
    if (contaC) n_conta++;
  endtask

  // One complete move starting in espera_jogada.
  task automatic move(input logic ig, input logic fc);
    step("mv_pulse", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mv_reg",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mv_cmp",   1'b0, fc,   ig,   1'b0, 1'b0);
    if (m == M_PROX) step("mv_prox", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m = M_INI;
    // Reset held with iniciar high: inicial, all outputs low.
    @(negedge clock);
    repeat (3) step("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step("start_prep", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("start_esp",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full winning game.
    n_conta = 0;
    for (int k = 0; k < 16; k++) move(1'b1, (k == 15));
    chk("win_contaC", n_conta, 15);
    chk("win_state", {28'd0, db_estado}, {28'd0, ST_FIM_ACERTOU});

    // Miss on the third move, then restart.
    step("rs_prep", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rs_esp",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_conta = 0;
    move(1'b1, 1'b0);
    move(1'b1, 1'b0);
    move(1'b0, 1'b0);
    chk("miss_contaC", n_conta, 2);
    chk("miss_errou", {31'd0, errou}, 32'd1);
    step("rs2_prep", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rs2_esp",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout, then simultaneous move and timeout.
    step("tmo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("tmo_prep", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("tmo_esp",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("jf_wins",  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("to_cmp",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in comparacao, between edges.
    #2 reset = 1'b0;
    m = M_INI;
    #1 chk("async_rst", {19'd0, w_obs}, {19'd0, expect_of(M_INI)});
    @(negedge clock);
    step("rst_low", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step("rst_rel_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Illegal state code recovers to inicial.
    force dut.r_estado = 4'b1111;
    #1 release dut.r_estado;
    m = M_BAD;
    chk("bad_code", {19'd0, w_obs}, {19'd0, expect_of(M_BAD)});
    step("bad_recover", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Move pulse in a terminal state is ignored.
    step("g_prep", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("g_esp",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) move(1'b1, (k == 15));
    step("ok_jf", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("ok_jf_ft", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      step("rnd",
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3)  == 0),
           ($urandom_range(0, 7)  != 0),
           ($urandom_range(0, 2)  == 0),
           ($urandom_range(0, 9)  == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
Moore state machine that sequences the memory-game datapath of Experimento 5. It takes the datapath status signals (fimC, igual, jogada_feita, fimT) and drives its control inputs (zeraC, contaC, zeraR, registraR, conta). It walks the player through the 16 ROM positions, one move at a time. The game ends in one of three terminal states: hit, miss, or timeout.

Parameters:
STATE_W, 4, width of state register and db_estado

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; forces state inicial
iniciar  input  1  level; starts/restarts a game from inicial or any terminal state
fimC  input  1  datapath: address counter at 15 (rco)
igual  input  1  datapath: ROM data equals registered move
jogada_feita  input  1  datapath: one-cycle pulse on a new move (edge of any key)
fimT  input  1  datapath: move-timeout counter expired
zeraC  output  1  clear address counter, timeout counter and edge detector
contaC  output  1  increment address counter
zeraR  output  1  clear move register
registraR  output  1  load chaves into move register
conta  output  1  enable timeout counter
pronto  output  1  game finished (any terminal state)
acertou  output  1  all 16 moves correct
errou  output  1  wrong move entered
timeout  output  1  no move before fimT
db_estado  output  4  current state code

Behaviour:
- Moore outputs, decoded combinationally from the state register only; the state register is the only storage.
- Async reset (reset=0): state = inicial immediately; all outputs 0 except db_estado=0000. State is held until reset=1.
- Default for every output not listed below is 0.
- State codes and per-state outputs:
  - inicial (0000): all outputs 0. iniciar=1 -> preparacao.
  - preparacao (0001): zeraC=1, zeraR=1. Always -> espera_jogada.
  - espera_jogada (0010): conta=1.
    - jogada_feita=1 -> registra.
    - else fimT=1 -> fim_timeout.
    - else stay.
    - If jogada_feita and fimT are both 1 in the same cycle, jogada_feita wins.
  - registra (0100): registraR=1. Always -> comparacao.
  - comparacao (0101):
    - igual=0 -> fim_errou.
    - else fimC=1 -> fim_acertou.
    - else -> proximo.
    - A miss at address 15 goes to fim_errou, not fim_acertou.
  - proximo (0110): contaC=1. Always -> espera_jogada.
  - fim_acertou (1010): pronto=1, acertou=1.
  - fim_errou (1110): pronto=1, errou=1.
  - fim_timeout (1101): pronto=1, timeout=1.
  - All three terminal states: iniciar=1 -> preparacao, else stay.
- Unused codes -> inicial on the next clock.
- Latency:
  - preparacao is 1 cycle after iniciar is sampled.
  - registra is 1 cycle after the jogada_feita pulse.
  - A decision is made 2 cycles after the jogada_feita pulse.
  - The address advances 3 cycles after the pulse.
  - The ROM is synchronous, so data for the new address is valid by the next comparacao (at least 2 cycles later).
- The timeout counter restarts via jogada_feita inside the datapath. The controller does not clear it between moves.
- iniciar is level-sensitive. If held high in a terminal state, the game restarts every time it reaches a terminal state; this is accepted behaviour.
- A jogada_feita pulse arriving outside espera_jogada is ignored.

Decomposition:
- Shared package: STATE_W, and localparam codes ST_INICIAL, ST_PREPARACAO, ST_ESPERA, ST_REGISTRA, ST_COMPARACAO, ST_PROXIMO, ST_FIM_ACERTOU, ST_FIM_ERROU, ST_FIM_TIMEOUT, with the values above. The datapath debug hex decoder uses the same package.
- No sub-module: a single module with a state register, next-state logic and output decode.
- The top level (circuito_exp5) instantiates unidade_controle_jogo alongside fluxo_dados.

Test Plan:
1. reset=0 with iniciar=1 -> db_estado=0000 and all outputs 0 throughout. Release reset with iniciar=1 -> 0001 next cycle with zeraC=zeraR=1, then 0010 with conta=1.
2. 16 moves, igual=1 each time, fimC=1 only on the 16th -> the sequence 0010->0100->0101->0110 repeats 15 times with exactly 15 contaC pulses. The 16th comparacao goes to 1010 with pronto=acertou=1.
3. igual=0 at the 3rd comparacao -> 1110 with pronto=errou=1, and contaC pulsed exactly 2 times. iniciar=1 -> 0001 then 0010.
4. In espera_jogada, fimT=1 with no jogada_feita -> 1101 with timeout=pronto=1. Separately, jogada_feita=fimT=1 in the same cycle -> 0100, not 1101.
5. Assert reset=0 mid-game (state 0101) between clock edges -> db_estado=0000 and all outputs 0 before the next edge. Release reset with iniciar=0 -> stays 0000.
6. Force state code 1111 -> 0000 on the next clock. A jogada_feita pulse in 1010 -> stays 1010.
